// File: rtl/img_filter_pkg.sv
// Shared encodings for the image-filter frame controller: FSM states,
// filter modes, sticky error bit positions and small counter helpers.
package img_filter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FLUSH  = 2'd2
  } state_e;

  localparam logic [1:0] MODE_BYPASS = 2'd0;
  localparam logic [1:0] MODE_MEDIAN = 2'd1;
  localparam logic [1:0] MODE_RSVD   = 2'd2;
  localparam logic [1:0] MODE_FREEZE = 2'd3;

  localparam int ERR_LINE_LEN    = 0;
  localparam int ERR_LINE_CNT    = 1;
  localparam int ERR_VSYNC_FLUSH = 2;

  // The reserved encoding is kept in the pending register but runs as bypass.
  function automatic logic [1:0] applied_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_BYPASS : m;
  endfunction

  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/img_sync_edge_det.sv
// Rise/fall detector against a one-cycle-delayed registered copy of the input.
module img_sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/img_filter_frame_ctrl.sv
// Frame sequencer for the image filter: tracks vsync/href framing, applies the
// configured mode per frame, drains the filter pipeline and flags framing errors.
//
// state     | meaning
// ST_IDLE   | waiting for vsync rise, datapath off
// ST_ACTIVE | frame in progress, counting pixels and lines
// ST_FLUSH  | frame ended, draining the filter pipeline
module img_filter_frame_ctrl
  import img_filter_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP    = 11'd640,
  parameter logic [10:0] IMG_VDISP    = 11'd480,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        cfg_wr,
  input  logic [1:0]  cfg_mode,
  input  logic        err_clr,
  output logic [1:0]  mode_sel,
  output logic        filter_en,
  output logic        busy,
  output logic        frame_done,
  output logic [2:0]  err_status,
  output logic [15:0] frame_cnt
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  logic vs_rise, vs_fall, hr_rise, hr_fall;

  state_e      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [10:0] pix_cnt_q, pix_cnt_d;
  logic [10:0] line_cnt_q, line_cnt_d;
  logic [1:0]  pend_mode_q, pend_mode_d;
  logic [1:0]  mode_q, mode_d;
  logic [2:0]  err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic        frame_start;
  logic [10:0] line_inc;
  logic [10:0] line_final;

  img_sync_edge_det u_vsync_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (per_frame_vsync),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  img_sync_edge_det u_href_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (per_frame_href),
    .rise_o (hr_rise),
    .fall_o (hr_fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (vs_rise) state_d = ST_ACTIVE;
      ST_ACTIVE: if (vs_fall) state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (vs_rise)                   state_d = ST_ACTIVE;
        else if (flush_cnt_q == 4'd0)  state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  // A vsync rise on the last drain cycle still aborts, so no frame_done then.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    frame_done  = (state_q == ST_FLUSH) && (flush_cnt_q == 4'd0) && !vs_rise;
    frame_start = vs_rise && (state_q != ST_ACTIVE);
  end

  assign line_inc   = sat_inc11(line_cnt_q);
  // A line ending together with the frame is counted before the check.
  assign line_final = hr_fall ? line_inc : line_cnt_q;

  always_comb begin
    pend_mode_d = cfg_wr ? cfg_mode : pend_mode_q;
    mode_d      = frame_start ? applied_mode(cfg_wr ? cfg_mode : pend_mode_q) : mode_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    flush_cnt_d = flush_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = err_clr ? 3'b000 : err_q;

    if (state_q == ST_ACTIVE) begin
      if (hr_rise)             pix_cnt_d = 11'd1;
      else if (per_frame_href) pix_cnt_d = sat_inc11(pix_cnt_q);

      if (hr_fall) begin
        if (pix_cnt_q != IMG_HDISP) err_d[ERR_LINE_LEN] = 1'b1;
        line_cnt_d = line_inc;
      end

      if (vs_fall) begin
        if (line_final != IMG_VDISP) err_d[ERR_LINE_CNT] = 1'b1;
        line_cnt_d  = 11'd0;
        pix_cnt_d   = 11'd0;
        flush_cnt_d = FLUSH_LOAD;
      end
    end

    if (state_q == ST_FLUSH) begin
      if (vs_rise)                  err_d[ERR_VSYNC_FLUSH] = 1'b1;
      else if (flush_cnt_q != 4'd0) flush_cnt_d = flush_cnt_q - 4'd1;
      if (frame_done)               frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_cnt_q <= 4'd0;
      pix_cnt_q   <= 11'd0;
      line_cnt_q  <= 11'd0;
      pend_mode_q <= MODE_BYPASS;
      mode_q      <= MODE_BYPASS;
      err_q       <= 3'b000;
      frame_cnt_q <= 16'd0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      pend_mode_q <= pend_mode_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign mode_sel   = mode_q;
  assign filter_en  = busy && (mode_q == MODE_MEDIAN);
  assign err_status = err_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_img_filter_frame_ctrl.sv
// Directed bench for img_filter_frame_ctrl with a frame-level reference model
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_img_filter_frame_ctrl;

  localparam int F = 4;

  logic        clk;
  logic        rst_n;
  logic        per_frame_vsync;
  logic        per_frame_href;
  logic        cfg_wr;
  logic [1:0]  cfg_mode;
  logic        err_clr;
  logic [1:0]  mode_sel;
  logic        filter_en;
  logic        busy;
  logic        frame_done;
  logic [2:0]  err_status;
  logic [15:0] frame_cnt;

  img_filter_frame_ctrl #(
    .IMG_HDISP    (11'd8),
    .IMG_VDISP    (11'd4),
    .FLUSH_CYCLES (F)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .per_frame_vsync (per_frame_vsync),
    .per_frame_href  (per_frame_href),
    .cfg_wr          (cfg_wr),
    .cfg_mode        (cfg_mode),
    .err_clr         (err_clr),
    .mode_sel        (mode_sel),
    .filter_en       (filter_en),
    .busy            (busy),
    .frame_done      (frame_done),
    .err_status      (err_status),
    .frame_cnt       (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 0;
  int fd_seen = 0;
  int fd_last = -1;

  // Frame-level model: each frame is its start cycle (vsync raised), end cycle
  // (vsync dropped, -1 while open) and the mode it runs with.
  typedef struct {
    int         s;
    int         e;
    logic [1:0] mode;
  } frame_t;

  frame_t     frames[$];
  logic [1:0] pending = 2'd0;
  int         last_e  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit aborted(input int i);
    if (frames[i].e < 0) return 1'b0;
    if (i + 1 < frames.size())
      return (frames[i+1].s > frames[i].e) && (frames[i+1].s <= frames[i].e + F);
    return 1'b0;
  endfunction

  function automatic logic exp_busy(input int k);
    for (int i = 0; i < frames.size(); i++)
      if (k >= frames[i].s + 1 && (frames[i].e < 0 || k <= frames[i].e + F)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_fd(input int k);
    for (int i = 0; i < frames.size(); i++)
      if (frames[i].e >= 0 && k == frames[i].e + F && !aborted(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [15:0] exp_fcnt(input int k);
    logic [15:0] n = 16'd0;
    for (int i = 0; i < frames.size(); i++)
      if (frames[i].e >= 0 && !aborted(i) && k >= frames[i].e + F + 1) n = n + 16'd1;
    return n;
  endfunction

  function automatic logic [1:0] exp_mode(input int k);
    for (int i = frames.size() - 1; i >= 0; i--)
      if (k >= frames[i].s + 1) return frames[i].mode;
    return 2'd0;
  endfunction

  always @(negedge clk) begin
    if (frame_done) begin
      fd_seen++;
      fd_last = cyc;
    end
    if (chk_en) begin
      chk("busy",       16'(busy),       16'(exp_busy(cyc)));
      chk("filter_en",  16'(filter_en),  16'(exp_busy(cyc) && exp_mode(cyc) == 2'd1));
      chk("mode_sel",   16'(mode_sel),   16'(exp_mode(cyc)));
      chk("frame_done", 16'(frame_done), 16'(exp_fd(cyc)));
      chk("frame_cnt",  frame_cnt,       exp_fcnt(cyc));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input logic [1:0] m);
    cfg_wr = 1'b1; cfg_mode = m; pending = m;
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic vs_rise(input bit cfg_en, input logic [1:0] m);
    frame_t f;
    f.s    = cyc;
    f.e    = -1;
    f.mode = ((cfg_en ? m : pending) == 2'd2) ? 2'd0 : (cfg_en ? m : pending);
    frames.push_back(f);
    per_frame_vsync = 1'b1;
    if (cfg_en) begin
      cfg_wr = 1'b1; cfg_mode = m; pending = m;
    end
    tick(1);
    cfg_wr = 1'b0;
  endtask

  task automatic line(input int len, input int gap);
    per_frame_href = 1'b1;
    tick(len);
    if (gap > 0) begin
      per_frame_href = 1'b0;
      tick(gap);
    end
  endtask

  task automatic vs_fall();
    frames[frames.size()-1].e = cyc;
    last_e = cyc;
    per_frame_vsync = 1'b0;
    per_frame_href  = 1'b0;
    tick(1);
  endtask

  task automatic body(input int n, input int short_idx, input bit nogap, input int tail);
    tick(2);
    for (int i = 0; i < n; i++)
      line((i == short_idx) ? 7 : 8, (nogap && i == n - 1) ? 0 : 2);
    vs_fall();
    tick(tail);
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("err_clr", 16'(err_status), 16'd0);
  endtask

  int fd_before;

  initial begin
    rst_n = 1'b0; per_frame_vsync = 1'b0; per_frame_href = 1'b0;
    cfg_wr = 1'b0; cfg_mode = 2'd0; err_clr = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rst_busy",  16'(busy),       16'd0);
    chk("rst_fen",   16'(filter_en),  16'd0);
    chk("rst_mode",  16'(mode_sel),   16'd0);
    chk("rst_fd",    16'(frame_done), 16'd0);
    chk("rst_err",   16'(err_status), 16'd0);
    chk("rst_fcnt",  frame_cnt,       16'd0);
    chk_en = 1;

    // Median mode, clean 4x8 frame
    cfg(2'd1);
    tick(2);
    vs_rise(0, 2'd0);
    chk("fen_at_start", 16'(filter_en), 16'd1);
    body(4, -1, 0, 8);
    chk("fd_delay", 16'(fd_last - last_e), 16'd4);
    chk("fd_count", 16'(fd_seen), 16'd1);
    chk("fcnt_1", frame_cnt, 16'd1);
    chk("err_clean", 16'(err_status), 16'd0);

    // One 7-pixel line
    vs_rise(0, 2'd0);
    body(4, 1, 0, 8);
    chk("err_short_line", 16'(err_status), 16'b001);
    chk("fcnt_2", frame_cnt, 16'd2);
    clear_err();

    // Too few, then too many lines
    vs_rise(0, 2'd0);
    body(3, -1, 0, 8);
    chk("err_3_lines", 16'(err_status), 16'b010);
    clear_err();
    vs_rise(0, 2'd0);
    body(5, -1, 0, 8);
    chk("err_5_lines", 16'(err_status), 16'b010);
    chk("fcnt_4", frame_cnt, 16'd4);
    clear_err();

    // Mid-frame config only affects the next frame
    vs_rise(0, 2'd0);
    tick(2);
    line(8, 2);
    line(8, 2);
    cfg(2'd0);
    chk("mode_hold_mid", 16'(mode_sel), 16'd1);
    line(8, 2);
    line(8, 2);
    vs_fall();
    tick(8);
    chk("mode_hold_idle", 16'(mode_sel), 16'd1);
    vs_rise(0, 2'd0);
    chk("mode_next_0", 16'(mode_sel), 16'd0);
    body(4, -1, 0, 8);
    vs_rise(1, 2'd1);
    chk("mode_coincident_1", 16'(mode_sel), 16'd1);
    chk("fen_coincident", 16'(filter_en), 16'd1);
    body(4, -1, 0, 8);
    vs_rise(1, 2'd2);
    chk("mode_rsvd_bypass", 16'(mode_sel), 16'd0);
    body(4, -1, 0, 8);
    chk("fcnt_8", frame_cnt, 16'd8);

    // Last href fall coincides with vsync fall; line must still be counted
    vs_rise(0, 2'd0);
    body(4, -1, 1, 8);
    chk("err_simul_fall", 16'(err_status), 16'd0);
    chk("fcnt_9", frame_cnt, 16'd9);

    // vsync re-rises two cycles into the drain
    vs_rise(1, 2'd1);
    body(4, -1, 0, 1);
    fd_before = fd_seen;
    vs_rise(0, 2'd0);
    chk("err_abort", 16'(err_status), 16'b100);
    chk("busy_abort", 16'(busy), 16'd1);
    tick(3);
    chk("fcnt_abort", frame_cnt, 16'd9);
    chk("fd_abort", 16'(fd_seen - fd_before), 16'd0);
    body(4, -1, 0, 8);
    chk("fcnt_10", frame_cnt, 16'd10);
    clear_err();

    // Reset in the middle of a line
    vs_rise(0, 2'd0);
    tick(2);
    line(8, 2);
    per_frame_href = 1'b1;
    tick(3);
    rst_n = 1'b0; per_frame_vsync = 1'b0; per_frame_href = 1'b0;
    frames.delete();
    pending = 2'd0;
    #1;
    chk("mrst_busy", 16'(busy),       16'd0);
    chk("mrst_fen",  16'(filter_en),  16'd0);
    chk("mrst_mode", 16'(mode_sel),   16'd0);
    chk("mrst_fd",   16'(frame_done), 16'd0);
    chk("mrst_fcnt", frame_cnt,       16'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    vs_rise(0, 2'd0);
    body(4, -1, 0, 8);
    chk("post_rst_fcnt", frame_cnt, 16'd1);
    chk("post_rst_err", 16'(err_status), 16'd0);
    chk("post_rst_mode", 16'(mode_sel), 16'd0);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/img_filter_frame_ctrl.md
IMG_FILTER_FRAME_CTRL -- requirements
Module: img_filter_frame_ctrl

Interface
REQ-001 Parameter IMG_HDISP, default 11'd640, expected active pixels per line.
REQ-002 Parameter IMG_VDISP, default 11'd480, expected active lines per frame.
REQ-003 Parameter FLUSH_CYCLES, default 4, filter pipeline drain time after frame end; range 1..15.
REQ-004 clk  input  1  single clock domain.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 per_frame_vsync  input  1  frame valid, high for the whole frame.
REQ-007 per_frame_href  input  1  line valid, high during active pixels.
REQ-008 cfg_wr  input  1  single-cycle config write strobe.
REQ-009 cfg_mode  input  2  requested mode: 0 bypass, 1 median 3x3, 2 reserved (treated as bypass), 3 freeze output.
REQ-010 err_clr  input  1  clears err_status.
REQ-011 mode_sel  output  2  mode applied to the current frame.
REQ-012 filter_en  output  1  datapath enable.
REQ-013 busy  output  1  high in ACTIVE or FLUSH.
REQ-014 frame_done  output  1  one-cycle pulse at FLUSH exit.
REQ-015 err_status  output  3  sticky errors: [0] line length, [1] line count, [2] vsync during FLUSH.
REQ-016 frame_cnt  output  16  completed-frame counter.

Function
REQ-017 Rising/falling edges of vsync and href SHALL be detected against a one-cycle-delayed registered copy; no other input synchronisation.
REQ-018 States: IDLE, ACTIVE, FLUSH.
REQ-019 IDLE -> ACTIVE on vsync rise; mode_sel loads the pending mode in that cycle.
REQ-020 A cfg_wr coincident with vsync rise SHALL apply to the frame starting in that cycle; cfg_wr at any other time updates only the pending register.
REQ-021 pending_mode values 2 and 3 SHALL be stored unchanged; mode_sel SHALL map 2 to 0 at frame-start load.
REQ-022 ACTIVE: pix_cnt (11-bit) increments each cycle href is high, saturating at 2047; cleared at every href rise.
REQ-023 ACTIVE: at href fall, if pix_cnt != IMG_HDISP set err_status[0]; line_cnt (11-bit, saturating) increments.
REQ-024 ACTIVE -> FLUSH on vsync fall; if line_cnt != IMG_VDISP set err_status[1]; line_cnt cleared at FLUSH entry.
REQ-025 Simultaneous href fall and vsync fall SHALL count the line before the line-count check.
REQ-026 FLUSH: 4-bit down counter loaded with FLUSH_CYCLES-1; at zero -> IDLE, frame_done pulses, frame_cnt increments with wrap at 16'hFFFF.
REQ-027 vsync rise during FLUSH SHALL set err_status[2], abort drain, skip frame_done and frame_cnt, and enter ACTIVE with a fresh mode load.
REQ-028 filter_en = busy AND mode_sel == 1.
REQ-029 err_clr clears err_status; an error event in the same cycle SHALL win (bit stays set).
REQ-030 Latency: state, mode_sel and filter_en change one cycle after the triggering input edge is sampled.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE; mode_sel, pending_mode, err_status, frame_cnt, all counters and edge registers 0; filter_en, busy, frame_done 0.
REQ-032 Reset mid-frame SHALL abandon the frame; the next vsync rise after release starts a clean frame.

Structure
REQ-033 Package img_filter_pkg SHALL hold the mode encodings, state enum and err_status bit indices.
REQ-034 Edge detection SHALL be one sub-module, img_sync_edge_det, instantiated for vsync and href.

Verification (IMG_HDISP=8, IMG_VDISP=4, FLUSH_CYCLES=4)
REQ-035 cfg_wr mode 1, then a 4x8 frame -> filter_en high from vsync rise+1 to FLUSH end, frame_done once 4 cycles after the FLUSH-entry cycle, frame_cnt=1, err_status=0.
REQ-036 A frame with one 7-pixel line -> err_status=3'b001; err_clr -> 0.
REQ-037 A 3-line frame -> err_status[1] set; a 5-line frame after clear -> err_status[1] set.
REQ-038 cfg_wr mode 0 mid-frame during mode 1 -> mode_sel stays 1 until the next vsync rise, then 0; a cfg_wr of mode 1 coincident with that vsync rise -> mode_sel=1.
REQ-039 vsync re-rises 2 cycles into FLUSH -> err_status[2]=1, frame_done absent, frame_cnt unchanged, state ACTIVE.
REQ-040 rst_n low mid-line -> all outputs 0 immediately; post-release frame completes with frame_cnt=1.
